cook_status_fsm: RTL and testbench
==================================

COOK_STATUS_FSM -- requirements
Module: cook_status_fsm

Interface
REQ-001 Parameter TICK_DIV, default 100: clk cycles per internal tick.
REQ-002 Parameter FINISH_TICKS, default 3000: ticks FINISH is held before auto-return to IDLE.
REQ-003 clk  input  1  single system clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 btn_set  input  1  one-clk pulse: user edits cook time.
REQ-006 btn_start  input  1  one-clk pulse: start/resume.
REQ-007 btn_stop  input  1  one-clk pulse: pause/cancel.
REQ-008 door_open  input  1  level: door open.
REQ-009 time_zero  input  1  level: remaining cook time is zero.
REQ-010 sel  output  2  {finish, setting} LED-mode code for the LED controller.
REQ-011 timer_run  output  1  countdown enable for the cook timer.
REQ-012 motor_en  output  1  turntable/magnetron enable.
REQ-013 state  output  3  encoded FSM state for debug/display.

Function
REQ-014 States: IDLE=0, SETTING=1, COOKING=2, PAUSED=3, FINISH=4; state register updates on posedge clk.
REQ-015 IDLE: btn_start & !time_zero -> COOKING; else btn_set -> SETTING; else stay.
REQ-016 SETTING: btn_start & !time_zero -> COOKING; else btn_stop -> IDLE; else stay.
REQ-017 COOKING: time_zero -> FINISH (highest priority); else btn_stop -> PAUSED; else stay.
REQ-018 PAUSED: btn_start & !time_zero -> COOKING; else btn_stop -> IDLE; else btn_set -> SETTING; else stay.
REQ-019 FINISH: any of btn_set/btn_start/btn_stop -> IDLE (acknowledge); else finish counter reaching FINISH_TICKS-1 on a tick -> IDLE.
REQ-020 btn_start with time_zero=1 is ignored in every state.
REQ-021 Outputs decoded from registered state only: sel[1]=(FINISH), sel[0]=(SETTING|PAUSED), timer_run=motor_en=(COOKING); change one cycle after the qualifying input edge.
REQ-022 Tick: one-clk pulse every TICK_DIV clocks, free-running from reset.
REQ-023 Finish counter width $clog2(FINISH_TICKS); cleared on entry to FINISH and in every other state; increments only on tick while in FINISH; no wrap reachable.
REQ-024 Multiple simultaneous buttons resolve by per-state priority above; no illegal state reachable; unused encodings 5-7 -> IDLE next cycle.

Reset
REQ-025 rst=0 at a posedge: state=IDLE, sel=2'b00, timer_run=0, motor_en=0, tick and finish counters=0; applies mid-operation from any state.
REQ-026 Inputs ignored during reset; first transition possible on first posedge with rst=1.

Configuration
REQ-027 Macro DOOR_INTERLOCK_EN defined: COOKING with door_open=1 -> PAUSED (below time_zero, above btn_stop); PAUSED->COOKING additionally requires door_open=0; IDLE/SETTING->COOKING additionally requires door_open=0.
REQ-028 DOOR_INTERLOCK_EN undefined: door_open has no effect on any output or transition.

Structure
REQ-029 Shared package holds the state enumeration/encoding and sel bit-position constants, shared with the LED controller and display logic.
REQ-030 One sub-module, tick_gen (TICK_DIV parameter, clk/rst in, tick out); FSM and finish counter in cook_status_fsm.

Verification (bench: TICK_DIV=4, FINISH_TICKS=5)
REQ-031 Reset, btn_set, btn_start with time_zero=0 -> sel 00->01->00, motor_en=1 one cycle after btn_start.
REQ-032 COOKING, time_zero=1 asserted with btn_stop same cycle -> FINISH (sel=10), not PAUSED.
REQ-033 FINISH with no buttons -> IDLE exactly after 5th tick (20+/-4 clks), sel returns 00.
REQ-034 FINISH, btn_stop at cycle 2 -> IDLE next cycle, finish counter 0.
REQ-035 With DOOR_INTERLOCK_EN: COOKING, door_open=1 -> PAUSED (sel=01, motor_en=0); btn_start while door_open=1 ignored; after door_open=0, btn_start -> COOKING.
REQ-036 rst=0 for one cycle during COOKING -> all outputs 0, state=IDLE next posedge; btn_start with time_zero=1 from IDLE -> stays IDLE.

Source files
------------

// File: rtl/cook_status_fsm_pkg.sv
// Shared state encoding and LED-mode bit positions for the cook status FSM,
// the LED controller and the display logic.
package cook_status_fsm_pkg;

    typedef logic [2:0] cook_state_t;

    localparam cook_state_t ST_IDLE    = 3'd0;
    localparam cook_state_t ST_SETTING = 3'd1;
    localparam cook_state_t ST_COOKING = 3'd2;
    localparam cook_state_t ST_PAUSED  = 3'd3;
    localparam cook_state_t ST_FINISH  = 3'd4;

    localparam int unsigned SEL_SETTING_BIT = 0;
    localparam int unsigned SEL_FINISH_BIT  = 1;

    // Counter width that stays legal when the modulus is 1.
    function automatic int unsigned cnt_width(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/cook_status_fsm_tick_gen.sv
// Free-running tick generator: one-clk pulse every TICK_DIV clocks from reset.
module tick_gen
    import cook_status_fsm_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = cnt_width(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = w_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cook_status_fsm.sv
// Microwave cook status FSM with FINISH auto-return timeout.
// Optional door interlock enabled by defining DOOR_INTERLOCK_EN.
module cook_status_fsm
    import cook_status_fsm_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 100,
    parameter int unsigned FINISH_TICKS = 3000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_set,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       door_open,
    input  logic       time_zero,
    output logic [1:0] sel,
    output logic       timer_run,
    output logic       motor_en,
    output logic [2:0] state
);

    localparam int unsigned FCW = cnt_width(FINISH_TICKS);
    localparam logic [FCW-1:0] FIN_LAST = FCW'(FINISH_TICKS - 1);

    cook_state_t    r_state;
    cook_state_t    w_next;
    logic [FCW-1:0] r_fin_cnt;
    logic           w_tick;
    logic           w_start_ok;
    logic           w_door_pause;
    logic           w_fin_done;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

`ifdef DOOR_INTERLOCK_EN
    assign w_start_ok   = btn_start & ~time_zero & ~door_open;
    assign w_door_pause = door_open;
`else
    logic w_unused_door;
    assign w_unused_door = door_open;
    assign w_start_ok    = btn_start & ~time_zero;
    assign w_door_pause  = 1'b0;
`endif

    assign w_fin_done = w_tick & (r_fin_cnt == FIN_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok)   w_next = ST_COOKING;
                else if (btn_set) w_next = ST_SETTING;
            end
            ST_SETTING: begin
                if (w_start_ok)    w_next = ST_COOKING;
                else if (btn_stop) w_next = ST_IDLE;
            end
            ST_COOKING: begin
                if (time_zero)         w_next = ST_FINISH;
                else if (w_door_pause) w_next = ST_PAUSED;
                else if (btn_stop)     w_next = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (w_start_ok)    w_next = ST_COOKING;
                else if (btn_stop) w_next = ST_IDLE;
                else if (btn_set)  w_next = ST_SETTING;
            end
            ST_FINISH: begin
                if (btn_set | btn_start | btn_stop) w_next = ST_IDLE;
                else if (w_fin_done)                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Clearing on any non-FINISH next state covers entry, exit and the timeout edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fin_cnt <= '0;
        end else if (w_next != ST_FINISH) begin
            r_fin_cnt <= '0;
        end else if (w_tick) begin
            r_fin_cnt <= r_fin_cnt + FCW'(1);
        end
    end

    assign sel[SEL_FINISH_BIT]  = (r_state == ST_FINISH);
    assign sel[SEL_SETTING_BIT] = (r_state == ST_SETTING) | (r_state == ST_PAUSED);
    assign timer_run            = (r_state == ST_COOKING);
    assign motor_en             = (r_state == ST_COOKING);
    assign state                = r_state;

endmodule

// File: tb/tb_cook_status_fsm.sv
// Directed self-checking bench for cook_status_fsm (TICK_DIV=4, FINISH_TICKS=5).
module tb_cook_status_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_set = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic       door_open = 1'b0;
    logic       time_zero = 1'b0;
    logic [1:0] sel;
    logic       timer_run;
    logic       motor_en;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    int fin_cycles;

    cook_status_fsm #(.TICK_DIV(4), .FINISH_TICKS(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_set   (btn_set),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .door_open (door_open),
        .time_zero (time_zero),
        .sel       (sel),
        .timer_run (timer_run),
        .motor_en  (motor_en),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks state plus every output decoded from the expected state.
    task automatic expect_st(input string tag, input int exp_st);
        int exp_sel;
        exp_sel = (exp_st == 4) ? 2 : ((exp_st == 1 || exp_st == 3) ? 1 : 0);
        chk({tag, ".state"}, int'(state), exp_st);
        chk({tag, ".sel"}, int'(sel), exp_sel);
        chk({tag, ".timer_run"}, int'(timer_run), (exp_st == 2) ? 1 : 0);
        chk({tag, ".motor_en"}, int'(motor_en), (exp_st == 2) ? 1 : 0);
    endtask

    task automatic pulse_set();   btn_set = 1'b1;   step(); btn_set = 1'b0;   endtask
    task automatic pulse_start(); btn_start = 1'b1; step(); btn_start = 1'b0; endtask
    task automatic pulse_stop();  btn_stop = 1'b1;  step(); btn_stop = 1'b0;  endtask

    initial begin
        // Reset, with buttons active to show they are ignored
        btn_start = 1'b1;
        btn_set   = 1'b1;
        step();
        step();
        btn_start = 1'b0;
        btn_set   = 1'b0;
        expect_st("reset", 0);
        chk("reset.fin_cnt", int'(dut.r_fin_cnt), 0);
        rst = 1'b1;

        // IDLE -> SETTING -> COOKING
        pulse_set();
        expect_st("idle_set", 1);
        pulse_start();
        expect_st("set_start", 2);

        // time_zero beats btn_stop in COOKING
        time_zero = 1'b1;
        pulse_stop();
        expect_st("cook_tz_stop", 4);

        // Auto return: 5th tick after entry lands 17..20 cycles later
        fin_cycles = 0;
        while (state == 3'd4 && fin_cycles < 40) begin
            step();
            fin_cycles++;
        end
        chk("fin_timeout_ge17", int'(fin_cycles >= 17), 1);
        chk("fin_timeout_le20", int'(fin_cycles <= 20), 1);
        expect_st("fin_timeout", 0);

        // FINISH acknowledged by btn_stop at cycle 2
        time_zero = 1'b0;
        pulse_start();
        expect_st("idle_start", 2);
        time_zero = 1'b1;
        step();
        expect_st("cook_tz", 4);
        step();
        step();
        expect_st("fin_hold", 4);
        pulse_stop();
        expect_st("fin_stop", 0);
        chk("fin_stop.fin_cnt", int'(dut.r_fin_cnt), 0);

        // PAUSED paths and same-cycle button priority
        time_zero = 1'b0;
        pulse_start();
        pulse_stop();
        expect_st("cook_stop", 3);
        pulse_set();
        expect_st("pause_set", 1);
        pulse_stop();
        expect_st("set_stop", 0);
        pulse_start();
        pulse_stop();
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        step();
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        expect_st("pause_start_stop", 2);
        pulse_stop();
        btn_stop = 1'b1;
        btn_set  = 1'b1;
        step();
        btn_stop = 1'b0;
        btn_set  = 1'b0;
        expect_st("pause_stop_set", 0);

        // Door behaviour
        pulse_start();
        expect_st("door_pre", 2);
        door_open = 1'b1;
        step();
`ifdef DOOR_INTERLOCK_EN
        expect_st("door_open_cook", 3);
        pulse_start();
        expect_st("door_open_start", 3);
        door_open = 1'b0;
        step();
        expect_st("door_closed", 3);
        pulse_start();
        expect_st("door_closed_start", 2);
`else
        expect_st("door_open_cook", 2);
        pulse_stop();
        expect_st("door_open_stop", 3);
        pulse_start();
        expect_st("door_open_start", 2);
        door_open = 1'b0;
`endif

        // Mid-operation reset from COOKING
        rst = 1'b0;
        step();
        rst = 1'b1;
        expect_st("mid_reset", 0);
        chk("mid_reset.fin_cnt", int'(dut.r_fin_cnt), 0);

        // btn_start ignored with time_zero=1
        time_zero = 1'b1;
        pulse_start();
        expect_st("idle_start_tz", 0);
        pulse_set();
        pulse_start();
        expect_st("set_start_tz", 1);
        pulse_stop();
        expect_st("set_stop2", 0);

        // FINISH acknowledged by btn_set goes to IDLE, not SETTING
        time_zero = 1'b0;
        pulse_start();
        time_zero = 1'b1;
        step();
        expect_st("fin_enter2", 4);
        time_zero = 1'b0;
        pulse_set();
        expect_st("fin_set_ack", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
